// File: rtl/data_memory_bank.sv
// Word-addressed data memory with per-byte write enables, registered read,
// full-width range checking and an optional post-reset clear sweep.
module data_memory_bank #(
    parameter int                 DATA_W         = 24,
    parameter int                 DEPTH          = 256,
    parameter int                 ADDR_W         = 24,
    parameter int                 CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0]  CLEAR_VAL      = {DATA_W{1'b0}}
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic [ADDR_W-1:0]     Adresa,
    input  logic [DATA_W-1:0]     WriteData,
    input  logic [DATA_W/8-1:0]   ByteEn,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    output logic [DATA_W-1:0]     ReadData,
    output logic                  ReadValid,
    output logic                  Ready,
    output logic                  AddrError
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Comparison is done at least 32 bits wide so neither DEPTH nor Adresa gets truncated.
    localparam int CMP_W = (ADDR_W > 32) ? ADDR_W : 32;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               ready_q, ready_d;
    logic [DATA_W-1:0]  read_data_q, read_data_d;
    logic               read_valid_q, read_valid_d;
    logic               addr_error_q, addr_error_d;

    logic               in_range_s;
    logic [IDX_W-1:0]   idx_s;
    logic               req_s;
    logic               sweep_we_s;
    logic [NB-1:0]      mem_we_s;
    logic [IDX_W-1:0]   mem_addr_s;
    logic [DATA_W-1:0]  mem_wdata_s;

    // Request decode and range check on the full address width.
    always_comb begin
        in_range_s = (CMP_W'(Adresa) < CMP_W'(DEPTH));
        idx_s      = Adresa[IDX_W-1:0];
        req_s      = ready_q && (MemRead || MemWrite);
    end

    // Sweep/idle state machine; Ready is registered from the next state.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sweep_we_s = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                sweep_we_s = 1'b1;
                if (ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    ptr_d   = {IDX_W{1'b0}};
                end else begin
                    ptr_d   = ptr_q + IDX_W'(1);
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = {IDX_W{1'b0}};
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // Array write port (sweep has priority) and registered read path.
    always_comb begin
        if (sweep_we_s) begin
            mem_we_s    = {NB{1'b1}};
            mem_addr_s  = ptr_q;
            mem_wdata_s = CLEAR_VAL;
        end else if (req_s && MemWrite && in_range_s) begin
            mem_we_s    = ByteEn;
            mem_addr_s  = idx_s;
            mem_wdata_s = WriteData;
        end else begin
            mem_we_s    = {NB{1'b0}};
            mem_addr_s  = idx_s;
            mem_wdata_s = WriteData;
        end

        // Reading the pre-edge array contents gives read-before-write on a shared address.
        if (req_s && MemRead && in_range_s) begin
            read_data_d  = mem_q[idx_s];
            read_valid_d = 1'b1;
        end else begin
            read_data_d  = read_data_q;
            read_valid_d = 1'b0;
        end

        addr_error_d = req_s && !in_range_s;
    end

    // Control and output registers.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q      <= RST_STATE;
            ptr_q        <= {IDX_W{1'b0}};
            ready_q      <= 1'b0;
            read_data_q  <= {DATA_W{1'b0}};
            read_valid_q <= 1'b0;
            addr_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ready_q      <= ready_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            addr_error_q <= addr_error_d;
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge Clock) begin
        for (int i = 0; i < NB; i++) begin
            if (mem_we_s[i]) begin
                mem_q[mem_addr_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
            end
        end
    end

    assign ReadData  = read_data_q;
    assign ReadValid = read_valid_q;
    assign Ready     = ready_q;
    assign AddrError = addr_error_q;

endmodule

// File: tb/tb_data_memory_bank.sv
// Randomized self-checking bench for data_memory_bank (DEPTH=16) against a
// behavioural array model of the memory, sweep and output registers.
module tb_data_memory_bank;

    localparam int          DW   = 24;
    localparam int          DEP  = 16;
    localparam logic [23:0] CVAL = 24'hA5A5A5;

    logic        Clock;
    logic        ResetN;
    logic [23:0] Adresa;
    logic [23:0] WriteData;
    logic [2:0]  ByteEn;
    logic        MemWrite;
    logic        MemRead;
    logic [23:0] ReadData;
    logic        ReadValid;
    logic        Ready;
    logic        AddrError;

    data_memory_bank #(
        .DATA_W(DW), .DEPTH(DEP), .ADDR_W(24), .CLEAR_ON_RESET(1), .CLEAR_VAL(CVAL)
    ) dut (
        .Clock(Clock), .ResetN(ResetN), .Adresa(Adresa), .WriteData(WriteData),
        .ByteEn(ByteEn), .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData),
        .ReadValid(ReadValid), .Ready(Ready), .AddrError(AddrError)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [23:0] m_mem [DEP];
    int          m_edges;
    logic [23:0] m_rd;

    task automatic check_eq(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        ResetN = 1'b0;
        #1;
        check_eq("rst_rdata", ReadData, 24'h000000);
        check_eq("rst_rvalid", {23'd0, ReadValid}, 24'd0);
        check_eq("rst_ready", {23'd0, Ready}, 24'd0);
        check_eq("rst_aerr", {23'd0, AddrError}, 24'd0);
        m_edges = 0;
        m_rd    = 24'h000000;
        @(negedge Clock);
        ResetN = 1'b1;
    endtask

    // One clock: drive, advance the model by one edge, compare all outputs.
    task automatic cyc(input logic we, input logic re, input logic [23:0] a,
                       input logic [23:0] wd, input logic [2:0] be);
        logic acc, inr, exp_rv, exp_err, exp_rdy;
        MemWrite  = we;
        MemRead   = re;
        Adresa    = a;
        WriteData = wd;
        ByteEn    = be;
        acc     = (m_edges >= DEP) && (we || re);
        inr     = (a < 24'd16);
        exp_rv  = acc && re && inr;
        exp_err = acc && !inr;
        if (exp_rv) m_rd = m_mem[a[3:0]];
        if (acc && we && inr) begin
            for (int i = 0; i < 3; i++) begin
                if (be[i]) m_mem[a[3:0]][8*i +: 8] = wd[8*i +: 8];
            end
        end
        if (m_edges < DEP) begin
            m_mem[m_edges] = CVAL;
            m_edges++;
        end
        exp_rdy = (m_edges >= DEP);
        @(posedge Clock);
        #1;
        check_eq("rdata", ReadData, m_rd);
        check_eq("rvalid", {23'd0, ReadValid}, {23'd0, exp_rv});
        check_eq("ready", {23'd0, Ready}, {23'd0, exp_rdy});
        check_eq("aerr", {23'd0, AddrError}, {23'd0, exp_err});
    endtask

    initial begin
        logic [23:0] a;
        int          r;
        ResetN = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
        Adresa = 24'd0; WriteData = 24'd0; ByteEn = 3'b000;
        m_edges = 0; m_rd = 24'd0;
        for (int i = 0; i < DEP; i++) m_mem[i] = 24'h000000;
        repeat (2) @(posedge Clock);
        #1;

        // Sweep: Ready stays low for 16 cycles; requests during it are ignored.
        apply_reset();
        for (int i = 0; i < DEP; i++) cyc(1'b1, 1'b1, 24'(i), 24'h123456, 3'b111);
        cyc(1'b0, 1'b1, 24'd0, 24'd0, 3'b000);
        check_eq("sweep_w0", ReadData, CVAL);
        cyc(1'b0, 1'b1, 24'd15, 24'd0, 3'b000);
        check_eq("sweep_w15", ReadData, CVAL);

        // Basic store/load.
        cyc(1'b1, 1'b0, 24'd2, 24'd30, 3'b111);
        cyc(1'b0, 1'b1, 24'd2, 24'd0, 3'b000);
        check_eq("load2", ReadData, 24'd30);
        cyc(1'b0, 1'b0, 24'd2, 24'd0, 3'b000);
        check_eq("hold2", ReadData, 24'd30);

        // Byte enables, including an all-zero mask.
        cyc(1'b1, 1'b0, 24'd5, 24'h112233, 3'b111);
        cyc(1'b1, 1'b0, 24'd5, 24'hFFFFFF, 3'b010);
        cyc(1'b1, 1'b0, 24'd5, 24'h000000, 3'b000);
        cyc(1'b0, 1'b1, 24'd5, 24'd0, 3'b000);
        check_eq("bytes5", ReadData, 24'h11FF33);

        // Simultaneous read and write: old data first.
        cyc(1'b1, 1'b0, 24'd7, 24'd9, 3'b111);
        cyc(1'b1, 1'b1, 24'd7, 24'd44, 3'b111);
        check_eq("rbw_old", ReadData, 24'd9);
        cyc(1'b0, 1'b1, 24'd7, 24'd0, 3'b000);
        check_eq("rbw_new", ReadData, 24'd44);

        // Out of range, including high bits that would alias into range if truncated.
        cyc(1'b1, 1'b0, 24'd16, 24'hDEAD01, 3'b111);
        cyc(1'b1, 1'b0, 24'h000102, 24'hDEAD02, 3'b111);
        cyc(1'b1, 1'b1, 24'h100003, 24'hDEAD03, 3'b111);
        cyc(1'b0, 1'b1, 24'hFFFFFF, 24'd0, 3'b000);
        cyc(1'b0, 1'b0, 24'd0, 24'd0, 3'b000);
        for (int i = 0; i < DEP; i++) cyc(1'b0, 1'b1, 24'(i), 24'd0, 3'b000);

        // Reset in the middle of the sweep, then a full sweep with writes attempted.
        apply_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 24'd1, 24'h777777, 3'b111);
        apply_reset();
        for (int i = 0; i < DEP; i++) cyc(1'b1, 1'b0, 24'(i), 24'h0BAD00, 3'b111);
        for (int i = 0; i < DEP; i++) cyc(1'b0, 1'b1, 24'(i), 24'd0, 3'b000);
        check_eq("midrst_w15", ReadData, CVAL);

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            r = int'($urandom_range(0, 19));
            if (r < 16)       a = 24'(r);
            else if (r == 16) a = 24'd16;
            else if (r == 17) a = 24'hFFFFFF;
            else              a = {8'($urandom_range(1, 255)), 12'h000, 4'($urandom_range(0, 15))};
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                24'($urandom), 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
